// File: rtl/lvdc_tel_pkg.sv
// Shared types and frame constants for the LVDC accumulator telemetry link.
// The transmitter, the matching receiver and the benches all import this package.
package lvdc_tel_pkg;

    localparam int unsigned TEL_WIDTH         = 26;
    localparam int unsigned TEL_PAD_BITS      = 1;
    localparam int unsigned TEL_FRAME_PERIODS = 29;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PAD,
        DATA,
        TAIL
    } tel_state_e;

endpackage

// File: rtl/lvdc_wda_gen.sv
// Free-running WDA shift clock: toggles every DIV SIM_CLK cycles.
// Also provides single-cycle enables that mark the SIM_CLK edge on which WDA falls or rises.
module lvdc_wda_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic wda_o,
    output logic wda_fall_o,
    output logic wda_rise_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wda_q, wda_d;
    logic            wrap;

    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        wda_d = wrap ? ~wda_q : wda_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            wda_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wda_q <= wda_d;
        end
    end

    assign wda_o      = wda_q;
    assign wda_fall_o = wrap & wda_q;
    assign wda_rise_o = wrap & ~wda_q;

endmodule

// File: rtl/lvdc_telemetry_tx.sv
// LVDC accumulator telemetry serializer: SYNC, PAD, 26 data periods MSB first, TAIL.
// PBV and AI3V only change on WDA falling edges so they are stable around every WDA rise.
module lvdc_telemetry_tx
    import lvdc_tel_pkg::*;
#(
    parameter int unsigned DIV   = 4,
    parameter int unsigned WIDTH = TEL_WIDTH
) (
    input  logic           SIM_CLK,
    input  logic           SIM_RST,
    input  logic [WIDTH:1] tx_data,
    input  logic           tx_valid,
    output logic           tx_ready,
    output logic           busy,
    output logic           frame_done,
    output logic           WDA,
    output logic           PBV,
    output logic           AI3V
);

    logic wda;
    logic wda_fall;
    logic wda_rise;

    lvdc_wda_gen #(
        .DIV (DIV)
    ) u_wda_gen (
        .clk_i      (SIM_CLK),
        .rst_i      (SIM_RST),
        .wda_o      (wda),
        .wda_fall_o (wda_fall),
        .wda_rise_o (wda_rise)
    );

    always_comb begin
        assert (!(wda_fall && wda_rise));
    end

    tel_state_e     state_q;
    logic [WIDTH:1] shreg_q;
    logic [4:0]     bit_cnt_q;
    logic           pending_q;
    logic           ready_q;
    logic           busy_q;
    logic           done_q;
    logic           pbv_q;
    logic           ai3v_q;
    logic           accept;

    assign accept = tx_valid & ready_q;

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pbv_q     <= 1'b0;
            ai3v_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Accept only happens in IDLE with nothing pending, so it never races the FSM below.
            if (accept) begin
                shreg_q   <= tx_data;
                pending_q <= 1'b1;
                ready_q   <= 1'b0;
                busy_q    <= 1'b1;
            end
            if (wda_fall) begin
                unique case (state_q)
                    IDLE: begin
                        if (pending_q) begin
                            state_q   <= SYNC;
                            pending_q <= 1'b0;
                            pbv_q     <= 1'b1;
                        end
                    end
                    SYNC: begin
                        state_q <= PAD;
                        pbv_q   <= 1'b0;
                    end
                    PAD: begin
                        state_q   <= DATA;
                        ai3v_q    <= shreg_q[WIDTH];
                        shreg_q   <= {shreg_q[WIDTH-1:1], 1'b0};
                        bit_cnt_q <= 5'(WIDTH);
                    end
                    DATA: begin
                        if (bit_cnt_q == 5'd1) begin
                            state_q <= TAIL;
                            ai3v_q  <= 1'b0;
                        end else begin
                            ai3v_q    <= shreg_q[WIDTH];
                            shreg_q   <= {shreg_q[WIDTH-1:1], 1'b0};
                            bit_cnt_q <= bit_cnt_q - 5'd1;
                        end
                    end
                    TAIL: begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign WDA        = wda;
    assign PBV        = pbv_q;
    assign AI3V       = ai3v_q;

endmodule

// File: tb/tb_lvdc_telemetry_tx.sv
// Directed bench for lvdc_telemetry_tx: a DIV=4 and a DIV=1 instance, each with a
// PBV/WDA-edge-counting receiver model and a per-cycle monitor.
module tb_lvdc_telemetry_tx;

    logic        SIM_CLK = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  vld;
    logic [1:0]  rdy, busy, done, wda, pbv, ai3v;
    logic [25:0] txd [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 SIM_CLK = ~SIM_CLK;

    lvdc_telemetry_tx #(.DIV(4), .WIDTH(26)) u_div4 (
        .SIM_CLK    (SIM_CLK),
        .SIM_RST    (rst[0]),
        .tx_data    (txd[0]),
        .tx_valid   (vld[0]),
        .tx_ready   (rdy[0]),
        .busy       (busy[0]),
        .frame_done (done[0]),
        .WDA        (wda[0]),
        .PBV        (pbv[0]),
        .AI3V       (ai3v[0])
    );

    lvdc_telemetry_tx #(.DIV(1), .WIDTH(26)) u_div1 (
        .SIM_CLK    (SIM_CLK),
        .SIM_RST    (rst[1]),
        .tx_data    (txd[1]),
        .tx_valid   (vld[1]),
        .tx_ready   (rdy[1]),
        .busy       (busy[1]),
        .frame_done (done[1]),
        .WDA        (wda[1]),
        .PBV        (pbv[1]),
        .AI3V       (ai3v[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_m
        int          n = 0;
        logic [25:0] vals [8];
        logic        active = 1'b0;
        int          cnt = 0;
        logic [25:0] acc = '0;
        int cyc = 0, run = 0, last_run = 0, rise_cyc = 0, done_cyc = 0, done_n = 0;
        int unstable = 0, rdy_viol = 0, wda_per = 0, wda_rcyc = 0;
        logic pbv_p = 1'b0, ai3v_p = 1'b0, wda_p = 1'b0;

        // Receiver: PBV=1 at a rise starts a frame; next rise is PAD, then 26 shifts, then latch.
        always @(posedge wda[g] or posedge rst[g]) begin
            if (rst[g]) begin
                active <= 1'b0;
                cnt    <= 0;
                acc    <= '0;
            end else if (pbv[g]) begin
                active <= 1'b1;
                cnt    <= 1;
                acc    <= '0;
            end else if (active) begin
                cnt <= cnt + 1;
                if (cnt >= 2 && cnt <= 27) acc <= {acc[24:0], ai3v[g]};
                if (cnt == 28) begin
                    vals[n % 8] <= acc;
                    n           <= n + 1;
                    active      <= 1'b0;
                end
            end
        end

        always @(negedge SIM_CLK) begin
            cyc    <= cyc + 1;
            pbv_p  <= pbv[g];
            ai3v_p <= ai3v[g];
            wda_p  <= wda[g];
            if (pbv[g]) run <= run + 1;
            else begin
                if (run != 0) last_run <= run;
                run <= 0;
            end
            if (pbv[g] && !pbv_p) rise_cyc <= cyc;
            if (done[g]) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
            if (wda[g] && !wda_p) begin
                wda_per  <= cyc - wda_rcyc;
                wda_rcyc <= cyc;
                if (pbv[g] !== pbv_p || ai3v[g] !== ai3v_p) unstable <= unstable + 1;
            end
            if (busy[g] && rdy[g]) rdy_viol <= rdy_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge SIM_CLK);
        #1;
    endtask

    task automatic send(input int g, input logic [25:0] d, input bit keep);
        int i;
        txd[g] = d;
        vld[g] = 1'b1;
        for (i = 0; i < 600 && !rdy[g]; i++) tick();
        check("accept_wait", {31'b0, rdy[g]}, 32'd1);
        @(posedge SIM_CLK);
        #1;
        if (!keep) vld[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int i;
        for (i = 0; i < 2000 && busy[g]; i++) tick();
        check("idle_wait", {31'b0, busy[g]}, 32'd0);
    endtask

    initial begin
        int i;
        int dc;
        rst    = 2'b11;
        vld    = 2'b00;
        txd[0] = '0;
        txd[1] = '0;
        repeat (3) tick();
        check("reset_outs_div4", {wda[0], pbv[0], ai3v[0], rdy[0], busy[0], done[0]}, 6'b000100);
        check("reset_outs_div1", {wda[1], pbv[1], ai3v[1], rdy[1], busy[1], done[1]}, 6'b000100);
        rst = 2'b00;
        repeat (20) tick();
        check("idle_wda_per_div4", g_m[0].wda_per, 8);
        check("idle_wda_per_div1", g_m[1].wda_per, 2);

        // Single word
        send(0, 26'h2AAAAAA, 1'b0);
        check("busy_after_accept", {30'b0, busy[0], rdy[0]}, 2'b10);
        wait_idle(0);
        check("single_n", g_m[0].n, 1);
        check("single_val", g_m[0].vals[0], 26'h2AAAAAA);
        check("single_pbv_len", g_m[0].last_run, 8);
        check("single_frame_len", g_m[0].done_cyc - g_m[0].rise_cyc, 232);
        check("single_done_n", g_m[0].done_n, 1);

        // Bit order
        send(0, 26'h0000001, 1'b0);
        wait_idle(0);
        check("lsb_val", g_m[0].vals[1], 26'h0000001);
        send(0, 26'h2000000, 1'b0);
        wait_idle(0);
        check("msb_val", g_m[0].vals[2], 26'h2000000);
        check("order_n", g_m[0].n, 3);

        // Back-to-back with tx_valid held high
        send(0, 26'h3FFFFFF, 1'b1);
        txd[0] = 26'h1234567;
        for (i = 0; i < 2000 && !done[0]; i++) tick();
        check("b2b_first_done", {31'b0, done[0]}, 32'd1);
        check("b2b_ready_after_done", {31'b0, rdy[0]}, 32'd1);
        #1;
        dc = g_m[0].done_cyc;
        @(posedge SIM_CLK);
        #1;
        vld[0] = 1'b0;
        check("b2b_second_accept", {31'b0, busy[0]}, 32'd1);
        wait_idle(0);
        check("b2b_val0", g_m[0].vals[3], 26'h3FFFFFF);
        check("b2b_val1", g_m[0].vals[4], 26'h1234567);
        check("b2b_done_n", g_m[0].done_n, 5);
        check("b2b_gap", g_m[0].rise_cyc - dc, 8);

        // Handshake: valid held, data changed mid-frame
        send(0, 26'h0F0F0F0, 1'b1);
        repeat (50) tick();
        txd[0] = 26'h3FFFFFF;
        check("hs_ready_low", {31'b0, rdy[0]}, 32'd0);
        for (i = 0; i < 2000 && !done[0]; i++) tick();
        vld[0] = 1'b0;
        repeat (2) tick();
        check("hs_no_reaccept", {31'b0, busy[0]}, 32'd0);
        check("hs_val", g_m[0].vals[5], 26'h0F0F0F0);
        check("hs_ready_busy_overlap", g_m[0].rdy_viol, 0);

        // Mid-frame reset during DATA bit 10 (a '1' bit of 155AAAA)
        send(0, 26'h155AAAA, 1'b0);
        for (i = 0; i < 100 && !pbv[0]; i++) tick();
        check("rst_sync_seen", {31'b0, pbv[0]}, 32'd1);
        repeat (90) tick();
        check("rst_pre_state", {29'b0, busy[0], pbv[0], ai3v[0]}, 3'b101);
        rst[0] = 1'b1;
        #1;
        check("rst_async_outs", {wda[0], pbv[0], ai3v[0], rdy[0], busy[0], done[0]}, 6'b000100);
        repeat (3) tick();
        rst[0] = 1'b0;
        repeat (3) tick();
        send(0, 26'h0ABCDEF, 1'b0);
        wait_idle(0);
        check("rst_recover_n", g_m[0].n, 7);
        check("rst_recover_val", g_m[0].vals[6], 26'h0ABCDEF);
        check("div4_stable", g_m[0].unstable, 0);

        // DIV=1
        send(1, 26'h3C3C3C3, 1'b0);
        wait_idle(1);
        check("div1_n", g_m[1].n, 1);
        check("div1_val", g_m[1].vals[0], 26'h3C3C3C3);
        check("div1_pbv_len", g_m[1].last_run, 2);
        check("div1_frame_len", g_m[1].done_cyc - g_m[1].rise_cyc, 58);
        check("div1_wda_per", g_m[1].wda_per, 2);
        check("div1_stable", g_m[1].unstable, 0);
        check("div1_done_n", g_m[1].done_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
